// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code decoder: maps a sampled code word to a phase index and one-hot
// vector, checks legality and ring order, tracks lock and counts errors.
module johnson_decoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     code_in,
    input  logic                 code_valid,
    input  logic                 err_clr,
    output logic [3:0]           phase,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 phase_valid,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
    output logic [7:0]           err_count
);

    localparam logic [0:0]         StUnlocked = 1'b0;
    localparam logic [0:0]         StLocked   = 1'b1;
    localparam logic [3:0]         LastPhase  = 4'(2 * WIDTH - 1);
    localparam logic [3:0]         LockCnt    = 4'(LOCK_COUNT);
    localparam logic [WIDTH-1:0]   Ones       = '1;
    localparam logic [2*WIDTH-1:0] OhOne      = {{(2 * WIDTH - 1){1'b0}}, 1'b1};

    // Phase k <= N fills ones from the bottom; phase k > N clears them from the bottom.
    function automatic logic [WIDTH-1:0] ring_code(input int unsigned k);
        if (k <= WIDTH) return ~(Ones << k);
        return Ones << (k - WIDTH);
    endfunction

    logic [3:0]         phase_q, phase_d;
    logic [2*WIDTH-1:0] onehot_q, onehot_d;
    logic               phase_valid_q, phase_valid_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;
    logic [0:0]         state_q, state_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic               have_prev_q, have_prev_d;
    logic [3:0]         prev_q, prev_d;
    logic [7:0]         err_count_q, err_count_d;

    logic               code_legal;
    logic [3:0]         code_idx;
    logic [2*WIDTH-1:0] code_onehot;
    logic [3:0]         succ_idx;

    always_comb begin
        code_legal  = 1'b0;
        code_idx    = '0;
        code_onehot = '0;
        for (int unsigned k = 0; k < 2 * WIDTH; k++) begin
            if (code_in == ring_code(k)) begin
                code_legal  = 1'b1;
                code_idx    = 4'(k);
                code_onehot = OhOne << k;
            end
        end
    end

    assign succ_idx = (prev_q == LastPhase) ? 4'd0 : prev_q + 4'd1;

    always_comb begin
        phase_d       = phase_q;
        onehot_d      = onehot_q;
        phase_valid_d = 1'b0;
        illegal_d     = 1'b0;
        seq_err_d     = 1'b0;
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        have_prev_d   = have_prev_q;
        prev_d        = prev_q;
        if (code_valid) begin
            if (code_legal) begin
                phase_d       = code_idx;
                onehot_d      = code_onehot;
                phase_valid_d = 1'b1;
                prev_d        = code_idx;
                have_prev_d   = 1'b1;
                if (!have_prev_q) begin
                    good_cnt_d = '0;
                end else if (code_idx == succ_idx) begin
                    good_cnt_d = (good_cnt_q < LockCnt) ? good_cnt_q + 4'd1 : LockCnt;
                    if (good_cnt_d == LockCnt) state_d = StLocked;
                end else if (code_idx != prev_q) begin
                    seq_err_d  = 1'b1;
                    good_cnt_d = '0;
                    state_d    = StUnlocked;
                end
            end else begin
                illegal_d   = 1'b1;
                onehot_d    = '0;
                have_prev_d = 1'b0;
                good_cnt_d  = '0;
                state_d     = StUnlocked;
            end
        end
    end

    // Clear wins over a coincident error.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if ((illegal_d || seq_err_d) && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= '0;
            onehot_q      <= '0;
            phase_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            state_q       <= StUnlocked;
            good_cnt_q    <= '0;
            have_prev_q   <= 1'b0;
            prev_q        <= '0;
            err_count_q   <= '0;
        end else begin
            phase_q       <= phase_d;
            onehot_q      <= onehot_d;
            phase_valid_q <= phase_valid_d;
            illegal_q     <= illegal_d;
            seq_err_q     <= seq_err_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            have_prev_q   <= have_prev_d;
            prev_q        <= prev_d;
            err_count_q   <= err_count_d;
        end
    end

    assign phase       = phase_q;
    assign onehot      = onehot_q;
    assign phase_valid = phase_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == StLocked);
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed self-checking bench for johnson_decoder (WIDTH=4, LOCK_COUNT=4).
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] phase;
    logic [7:0] onehot;
    logic       phase_valid;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] RING [0:8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                          4'b1110, 4'b1100, 4'b1000, 4'b0000};
    localparam logic [7:0] RING_OH [0:8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h01};

    johnson_decoder #(.WIDTH(4), .LOCK_COUNT(4)) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .err_clr(err_clr), .phase(phase), .onehot(onehot), .phase_valid(phase_valid),
        .illegal(illegal), .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] c, input logic v, input logic clr);
        code_in    = c;
        code_valid = v;
        err_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(4'b0011, 1'b1, 1'b0);
        drive(4'b0011, 1'b1, 1'b0);
        checks++;
        if ({phase, onehot, phase_valid, illegal, seq_err, locked} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ph=%0d oh=%h pv=%b il=%b se=%b lk=%b want all 0",
                     phase, onehot, phase_valid, illegal, seq_err, locked);
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++; $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_ring;
        for (int i = 0; i < 9; i++) begin
            drive(RING[i], 1'b1, 1'b0);
            checks++;
            if (phase !== 4'(i % 8) || onehot !== RING_OH[i] || phase_valid !== 1'b1) begin
                errors++;
                $display("FAIL ring_phase[%0d]: got ph=%0d oh=%h pv=%b want ph=%0d oh=%h pv=1",
                         i, phase, onehot, phase_valid, i % 8, RING_OH[i]);
            end
            checks++;
            if (locked !== (i >= 4) || seq_err !== 1'b0 || err_count !== 8'd0) begin
                errors++;
                $display("FAIL ring_lock[%0d]: got lk=%b se=%b ec=%0d want lk=%b se=0 ec=0",
                         i, locked, seq_err, err_count, i >= 4);
            end
        end
    endtask

    task automatic test_illegal;
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0011, 1'b1, 1'b0);
        drive(4'b0111, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || phase !== 4'd3) begin
            errors++; $display("FAIL illegal_pre: got lk=%b ph=%0d want lk=1 ph=3", locked, phase);
        end
        drive(4'b0101, 1'b1, 1'b0);
        checks++;
        if (illegal !== 1'b1 || onehot !== 8'h00 || phase !== 4'd3 || phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: got il=%b oh=%h ph=%0d pv=%b want il=1 oh=00 ph=3 pv=0",
                     illegal, onehot, phase, phase_valid);
        end
        checks++;
        if (locked !== 1'b0 || err_count !== 8'd1 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_state: got lk=%b ec=%0d se=%b want lk=0 ec=1 se=0",
                     locked, err_count, seq_err);
        end
        drive(4'b1111, 1'b1, 1'b0);
        checks++;
        if (phase_valid !== 1'b1 || seq_err !== 1'b0 || illegal !== 1'b0 || phase !== 4'd4) begin
            errors++;
            $display("FAIL illegal_recover: got pv=%b se=%b il=%b ph=%0d want pv=1 se=0 il=0 ph=4",
                     phase_valid, seq_err, illegal, phase);
        end
    endtask

    task automatic test_seq_err;
        drive(4'b1110, 1'b1, 1'b0);
        drive(4'b1100, 1'b1, 1'b0);
        drive(4'b1000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0011, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || phase !== 4'd2) begin
            errors++; $display("FAIL seq_pre: got lk=%b ph=%0d want lk=1 ph=2", locked, phase);
        end
        drive(4'b1110, 1'b1, 1'b0);
        checks++;
        if (seq_err !== 1'b1 || illegal !== 1'b0 || phase !== 4'd5 || onehot !== 8'h20) begin
            errors++;
            $display("FAIL seq_pulse: got se=%b il=%b ph=%0d oh=%h want se=1 il=0 ph=5 oh=20",
                     seq_err, illegal, phase, onehot);
        end
        checks++;
        if (locked !== 1'b0 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL seq_state: got lk=%b ec=%0d want lk=0 ec=2", locked, err_count);
        end
        drive(4'b1100, 1'b1, 1'b0);
        drive(4'b1000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL seq_relock_early: got lk=%b want 0", locked);
        end
        drive(4'b0001, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL seq_relock: got lk=%b want 1", locked);
        end
    endtask

    task automatic test_hold;
        drive(4'b0101, 1'b1, 1'b0);
        drive(4'b0011, 1'b1, 1'b0);
        drive(4'b0111, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            drive(4'b0111, 1'b0, 1'b0);
            checks++;
            if (phase_valid !== 1'b0 || seq_err !== 1'b0 || illegal !== 1'b0
                || phase !== 4'd3 || onehot !== 8'h08) begin
                errors++;
                $display("FAIL hold_idle[%0d]: got pv=%b se=%b il=%b ph=%0d oh=%h want 0,0,0,3,08",
                         r, phase_valid, seq_err, illegal, phase, onehot);
            end
            drive(4'b0111, 1'b1, 1'b0);
            checks++;
            if (phase_valid !== 1'b1 || seq_err !== 1'b0 || phase !== 4'd3) begin
                errors++;
                $display("FAIL hold_repeat[%0d]: got pv=%b se=%b ph=%0d want pv=1 se=0 ph=3",
                         r, phase_valid, seq_err, phase);
            end
        end
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1110, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL hold_lock_early: got lk=%b want 0", locked);
        end
        drive(4'b1100, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd3) begin
            errors++;
            $display("FAIL hold_lock: got lk=%b ec=%0d want lk=1 ec=3", locked, err_count);
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 260; i++) drive(4'b1010, 1'b1, 1'b0);
        checks++;
        if (err_count !== 8'd255 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: got ec=%0d il=%b want ec=255 il=1", err_count, illegal);
        end
        drive(4'b0101, 1'b1, 1'b1);
        checks++;
        if (err_count !== 8'd0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear: got ec=%0d il=%b want ec=0 il=1", err_count, illegal);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 7; i++) drive(RING[i], 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || phase !== 4'd6) begin
            errors++; $display("FAIL mid_pre: got lk=%b ph=%0d want lk=1 ph=6", locked, phase);
        end
        reset = 1'b1;
        drive(4'b1000, 1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if ({phase, onehot, phase_valid, illegal, seq_err, locked, err_count} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset: got ph=%0d oh=%h pv=%b il=%b se=%b lk=%b ec=%0d want all 0",
                     phase, onehot, phase_valid, illegal, seq_err, locked, err_count);
        end
        drive(4'b1000, 1'b1, 1'b0);
        checks++;
        if (phase !== 4'd7 || onehot !== 8'h80 || phase_valid !== 1'b1 || seq_err !== 1'b0
            || locked !== 1'b0) begin
            errors++;
            $display("FAIL mid_first: got ph=%0d oh=%h pv=%b se=%b lk=%b want 7,80,1,0,0",
                     phase, onehot, phase_valid, seq_err, locked);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ring();
        test_illegal();
        test_seq_err();
        test_hold();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- Receive-side companion to the 4-bit Johnson (twisted-ring) counter.
- Samples a Johnson code word and decodes it to a binary phase index and a one-hot phase vector.
- Checks that each code is legal and follows the ring order. Tracks lock status and counts errors.
- Sits downstream of any Johnson-counter-driven sequencer; feeds phase-select logic and error reporting.

Parameters:
- WIDTH, 4: Johnson code width N; legal range 2..8; ring has 2N states.
- LOCK_COUNT, 4: consecutive valid advances required to assert locked; range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- code_in  input  WIDTH  Johnson code word; bit 0 is the stage fed by the inverted MSB.
- code_valid  input  1  code_in is sampled on this edge when high.
- err_clr  input  1  synchronous clear of err_count.
- phase  output  4  binary phase index 0..2N-1.
- onehot  output  2*WIDTH  one-hot phase; bit k set for phase k.
- phase_valid  output  1  one-cycle pulse: phase/onehot updated from a legal sample.
- illegal  output  1  one-cycle pulse: the sampled code is not a legal Johnson word.
- seq_err  output  1  one-cycle pulse: code is legal but is neither the previous code nor its successor.
- locked  output  1  level: ring sequence is tracking.
- err_count  output  8  saturating count of illegal plus seq_err events.

Behaviour:
- Reset, synchronous on the clk edge with reset high:
  - phase=0, onehot=0.
  - phase_valid, illegal, seq_err, locked all 0.
  - err_count=0.
  - FSM=UNLOCKED; good_cnt=0; have_prev=0.
  - reset overrides every other input, including mid-sequence.
- Legal codes, phase k:
  - 0<=k<=N: the low k bits are 1, the rest 0.
  - N<k<2N: the low k-N bits are 0, the rest 1.
  - For N=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
  - Successor of phase k is phase (k+1) mod 2N; phase 2N-1 wraps to phase 0.
- Latency: all outputs are registered. Results for a sample taken at edge t appear after edge t and are valid during cycle t+1.
- code_valid=0:
  - No state change; phase, onehot and locked hold.
  - phase_valid, illegal and seq_err are 0.
- Legal sample:
  - phase=k, onehot=1<<k, phase_valid=1.
  - If have_prev=1 and k == prev: hold, no error, good_cnt unchanged.
  - If have_prev=1 and k == succ(prev): advance, good_cnt+1 (saturating at LOCK_COUNT).
  - If have_prev=1 and k is anything else: seq_err=1, good_cnt=0.
  - If have_prev=0: no check is made; good_cnt=0.
  - In every case: prev=k, have_prev=1.
- Illegal sample:
  - illegal=1, phase_valid=0.
  - phase holds; onehot=0.
  - have_prev=0, good_cnt=0.
- FSM:
  - UNLOCKED -> LOCKED when an advance brings good_cnt to LOCK_COUNT. locked rises in the same cycle as that phase_valid.
  - LOCKED -> UNLOCKED on any illegal or seq_err. locked falls in the same cycle as the error pulse.
  - Holds (repeated code) never change FSM state.
- err_count:
  - +1 on each illegal or seq_err, in either FSM state.
  - Saturates at 255.
  - err_clr takes priority over an error in the same cycle: result is 0.
- illegal and seq_err are mutually exclusive.
- onehot has at most one bit set.

Test Plan:
- Reset, then feed the full ring 0000,0001,0011,0111,1111,1110,1100,1000,0000 with code_valid=1 every cycle:
  - phase = 0..7, 0, each appearing one cycle after its sample.
  - locked rises with the 5th sample (good_cnt=4); err_count=0.
- While locked, at phase 3 (0111), insert 0101:
  - illegal=1, onehot=0, phase holds at 3, locked=0, err_count=1.
  - A following 1111 gives phase_valid=1, seq_err=0.
- While locked at phase 2 (0011), feed 1110:
  - seq_err=1, phase=5, locked=0, err_count+1.
  - Relock requires 4 further consecutive advances.
- Repeat 0111 three times, and drop code_valid between samples:
  - No seq_err; good_cnt unchanged.
  - phase_valid=0 in each cycle with code_valid low.
- Drive 260 illegal codes:
  - err_count saturates at 255.
  - Assert err_clr together with another illegal code: err_count=0.
- Assert reset mid-ring while locked at phase 6:
  - Next cycle all outputs are 0.
  - The first post-reset sample 1000 gives phase=7 with no seq_err.
